// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset CPU (fetch/decode/execute/memory/write-back).
// Build option: define MCPU_MIO_WAIT_EN to honour MIO_ready wait states; otherwise memory is single-cycle.
module mcpu_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ext_zero,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_IF       = 5'd0,
    S_ID       = 5'd1,
    S_MEM_ADDR = 5'd2,
    S_MEM_RD   = 5'd3,
    S_LW_WB    = 5'd4,
    S_MEM_WR   = 5'd5,
    S_R_EXE    = 5'd6,
    S_R_WB     = 5'd7,
    S_BR_EXE   = 5'd8,
    S_I_EXE    = 5'd9,
    S_I_WB     = 5'd10,
    S_LUI_WB   = 5'd11,
    S_JMP      = 5'd12,
    S_JAL      = 5'd13,
    S_JR       = 5'd14,
    S_JALR     = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_reg;
  state_t     state_next;
  logic       ready;
  logic [2:0] r_alu_op;
  logic       r_valid;
  logic [2:0] i_alu_op;
  logic       i_zero_ext;

`ifdef MCPU_MIO_WAIT_EN
  assign ready = MIO_ready;
`else
  // Single-cycle memory: the handshake is tied off and never stalls.
  logic unused_mio_ready;
  assign unused_mio_ready = MIO_ready;
  assign ready = 1'b1;
`endif

  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    r_alu_op = ALU_ADD;
    r_valid  = 1'b1;
    case (Fun)
      F_ADD:   r_alu_op = ALU_ADD;
      F_SUB:   r_alu_op = ALU_SUB;
      F_AND:   r_alu_op = ALU_AND;
      F_OR:    r_alu_op = ALU_OR;
      F_XOR:   r_alu_op = ALU_XOR;
      F_NOR:   r_alu_op = ALU_NOR;
      F_SLT:   r_alu_op = ALU_SLT;
      F_SRL:   r_alu_op = ALU_SRL;
      default: r_valid  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu_op   = ALU_ADD;
    i_zero_ext = 1'b0;
    case (OPcode)
      OP_SLTI: i_alu_op = ALU_SLT;
      OP_ANDI: begin i_alu_op = ALU_AND; i_zero_ext = 1'b1; end
      OP_ORI:  begin i_alu_op = ALU_OR;  i_zero_ext = 1'b1; end
      OP_XORI: begin i_alu_op = ALU_XOR; i_zero_ext = 1'b1; end
      default: i_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next  = S_IF;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ext_zero    = 1'b0;
    PCSource    = 2'b00;
    ALU_Control = ALU_AND;
    CPU_MIO     = 1'b0;
    case (state_reg)
      S_IF: begin
        CPU_MIO     = 1'b1;
        MemRead     = 1'b1;
        ALUSrcB     = 2'b01;
        ALU_Control = ALU_ADD;
        IRWrite     = ready;
        PCWrite     = ready;
        state_next  = ready ? S_ID : S_IF;
      end
      S_ID: begin
        // ALUOut captures PC+4 + (imm<<2) for a possible branch.
        ALUSrcB     = 2'b11;
        ALU_Control = ALU_ADD;
        case (OPcode)
          OP_RTYPE: begin
            if (Fun == F_JR)        state_next = S_JR;
            else if (Fun == F_JALR) state_next = S_JALR;
            else if (r_valid)       state_next = S_R_EXE;
            else                    state_next = S_IF;
          end
          OP_LW, OP_SW:                               state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                             state_next = S_BR_EXE;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_next = S_I_EXE;
          OP_LUI:                                     state_next = S_LUI_WB;
          OP_J:                                       state_next = S_JMP;
          OP_JAL:                                     state_next = S_JAL;
          default:                                    state_next = S_IF;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ALU_Control = ALU_ADD;
        state_next  = (OPcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        CPU_MIO    = 1'b1;
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = ready ? S_LW_WB : S_MEM_RD;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEM_WR: begin
        CPU_MIO    = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        state_next = ready ? S_IF : S_MEM_WR;
      end
      S_R_EXE: begin
        ALUSrcA     = (Fun == F_SRL) ? 2'b10 : 2'b01;
        ALU_Control = r_alu_op;
        state_next  = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_BR_EXE: begin
        ALUSrcA     = 2'b01;
        ALU_Control = ALU_SUB;
        PCSource    = 2'b01;
        PCWrite     = (OPcode == OP_BNE) ? ~zero : zero;
      end
      S_I_EXE: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ALU_Control = i_alu_op;
        ext_zero    = i_zero_ext;
        state_next  = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_LUI_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      S_JALR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        MemtoReg = 2'b11;
      end
      default: state_next = S_IF;
    endcase

    // Reset silences every strobe in the same cycle, aborting any access.
    if (rst) begin
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ext_zero    = 1'b0;
      PCSource    = 2'b00;
      ALU_Control = ALU_AND;
      CPU_MIO     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Randomized self-checking bench for mcpu_ctrl_fsm; follows MCPU_MIO_WAIT_EN like the design.
module tb_mcpu_ctrl_fsm;

`ifdef MCPU_MIO_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic       ext_zero, CPU_MIO;
  logic [2:0] ALU_Control;
  logic [4:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ext_zero(ext_zero), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .CPU_MIO(CPU_MIO), .state(state)
  );

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [2:0] alu_control;
    logic       cpu_mio;
  } ctl_t;

  typedef enum int {K_LW, K_SW, K_R, K_JR, K_JALR, K_BEQ, K_BNE, K_I, K_LUI, K_J, K_JAL, K_NOP} kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fun;
    kind_t      kind;
    logic [2:0] alu;
    logic       ext;
    logic       shamt;
  } instr_t;

  ctl_t act;
  assign act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ext_zero, PCSource, ALU_Control, CPU_MIO};

  instr_t tbl[$];

  function automatic instr_t mk(logic [5:0] op, logic [5:0] fun, kind_t k,
                                logic [2:0] alu, logic ext, logic sh);
    instr_t r;
    r.op = op; r.fun = fun; r.kind = k; r.alu = alu; r.ext = ext; r.shamt = sh;
    return r;
  endfunction

  // Instruction-level step sequence with no wait states.
  function automatic int path_len(kind_t k);
    case (k)
      K_LW:            return 5;
      K_SW, K_R, K_I:  return 4;
      K_NOP:           return 2;
      default:         return 3;
    endcase
  endfunction

  function automatic int path_state(kind_t k, int i);
    if (i == 0) return 0;
    if (i == 1) return 1;
    case (k)
      K_LW:         return (i == 2) ? 2 : (i == 3) ? 3 : 4;
      K_SW:         return (i == 2) ? 2 : 5;
      K_R:          return (i == 2) ? 6 : 7;
      K_I:          return (i == 2) ? 9 : 10;
      K_BEQ, K_BNE: return 8;
      K_LUI:        return 11;
      K_J:          return 12;
      K_JAL:        return 13;
      K_JR:         return 14;
      K_JALR:       return 15;
      default:      return 0;
    endcase
  endfunction

  function automatic ctl_t exp_ctl(int st, instr_t ins, logic z, logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.cpu_mio = 1; c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_control = 3'b010;
                c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.alu_src_b = 2'b11; c.alu_control = 3'b010; end
      2:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_control = 3'b010; end
      3:  begin c.cpu_mio = 1; c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      5:  begin c.cpu_mio = 1; c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = ins.shamt ? 2'b10 : 2'b01; c.alu_control = ins.alu; end
      7:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
      8:  begin c.alu_src_a = 2'b01; c.alu_control = 3'b110; c.pc_source = 2'b01;
                c.pc_write = (ins.kind == K_BEQ) ? z : ~z; end
      9:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_control = ins.alu;
                c.ext_zero = ins.ext; end
      10: c.reg_write = 1;
      11: begin c.reg_write = 1; c.mem_to_reg = 2'b10; end
      12: begin c.pc_write = 1; c.pc_source = 2'b10; end
      13: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10;
                c.mem_to_reg = 2'b11; end
      14: begin c.pc_write = 1; c.pc_source = 2'b11; end
      15: begin c.pc_write = 1; c.pc_source = 2'b11; c.reg_write = 1; c.reg_dst = 2'b01;
                c.mem_to_reg = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic build_table();
    tbl.push_back(mk(6'b000000, 6'b100000, K_R, 3'b010, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b100010, K_R, 3'b110, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b100100, K_R, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b100101, K_R, 3'b001, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b100110, K_R, 3'b011, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b100111, K_R, 3'b100, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b101010, K_R, 3'b111, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b000010, K_R, 3'b101, 0, 1));
    tbl.push_back(mk(6'b000000, 6'b001000, K_JR, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b001001, K_JALR, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b000000, K_NOP, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b011000, K_NOP, 3'b000, 0, 0));
    tbl.push_back(mk(6'b001000, 6'b000000, K_I, 3'b010, 0, 0));
    tbl.push_back(mk(6'b001010, 6'b000000, K_I, 3'b111, 0, 0));
    tbl.push_back(mk(6'b001100, 6'b000000, K_I, 3'b000, 1, 0));
    tbl.push_back(mk(6'b001101, 6'b000000, K_I, 3'b001, 1, 0));
    tbl.push_back(mk(6'b001110, 6'b000000, K_I, 3'b011, 1, 0));
    tbl.push_back(mk(6'b100011, 6'b000000, K_LW, 3'b000, 0, 0));
    tbl.push_back(mk(6'b101011, 6'b000000, K_SW, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000100, 6'b000000, K_BEQ, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000101, 6'b000000, K_BNE, 3'b000, 0, 0));
    tbl.push_back(mk(6'b001111, 6'b000000, K_LUI, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000010, 6'b000000, K_J, 3'b000, 0, 0));
    tbl.push_back(mk(6'b000011, 6'b000000, K_JAL, 3'b000, 0, 0));
    tbl.push_back(mk(6'b111111, 6'b000000, K_NOP, 3'b000, 0, 0));
    tbl.push_back(mk(6'b010000, 6'b000000, K_NOP, 3'b000, 0, 0));
  endtask

  // Entered and left one time unit after a rising edge with the DUT expected in IF.
  task automatic run_instr(input instr_t ins, input int if_waits, input int mem_waits, input logic z);
    int   idx;
    int   n;
    int   st;
    int   iw;
    int   mw;
    int   cyc;
    logic waitable;
    logic rdy;
    logic zz;
    ctl_t exp;
    idx = 0; n = path_len(ins.kind); iw = if_waits; mw = mem_waits; cyc = 0;
    while (idx < n) begin
      st       = path_state(ins.kind, idx);
      waitable = (st == 0) || (st == 3) || (st == 5);
      if (waitable) rdy = (st == 0) ? (iw == 0) : (mw == 0);
      else          rdy = 1'($urandom_range(0, 1));
      zz        = (st == 8) ? z : 1'($urandom_range(0, 1));
      OPcode    = ins.op;
      Fun       = ins.fun;
      MIO_ready = rdy;
      zero      = zz;
      exp       = exp_ctl(st, ins, zz, WAIT_EN ? rdy : 1'b1);
      @(negedge clk);
      checks++;
      if (state !== 5'(st)) begin
        errors++;
        $display("FAIL state op=%b fun=%b cycle=%0d got=%0d exp=%0d", ins.op, ins.fun, cyc, state, st);
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL ctl op=%b fun=%b state=%0d got=%h exp=%h", ins.op, ins.fun, st, act, exp);
      end
      @(posedge clk); #1;
      cyc++;
      if (waitable && !rdy) begin
        if (st == 0) iw--; else mw--;
        if (!WAIT_EN) idx++;
      end else begin
        idx++;
      end
    end
    $display("instr op=%b fun=%b kind=%0d z=%0b cycles=%0d", ins.op, ins.fun, ins.kind, z, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; OPcode = 6'b100011; Fun = 6'b0; zero = 1'b1; MIO_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (act !== ctl_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", act);
    end
    checks++;
    if (state !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=0", state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_add();
    run_instr(mk(6'b000000, 6'b100000, K_R, 3'b010, 0, 0), 0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    run_instr(mk(6'b100011, 6'b010101, K_LW, 3'b000, 0, 0), 0, 2, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(mk(6'b000100, 6'b000000, K_BEQ, 3'b000, 0, 0), 0, 0, 1'b1);
    run_instr(mk(6'b000101, 6'b000000, K_BNE, 3'b000, 0, 0), 0, 0, 1'b1);
    run_instr(mk(6'b000100, 6'b000000, K_BEQ, 3'b000, 0, 0), 0, 0, 1'b0);
    run_instr(mk(6'b000101, 6'b000000, K_BNE, 3'b000, 0, 0), 0, 0, 1'b0);
  endtask

  task automatic test_jal();
    run_instr(mk(6'b000011, 6'b110011, K_JAL, 3'b000, 0, 0), 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    OPcode = 6'b101011; Fun = 6'b0; MIO_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 5'(i)) begin
        errors++;
        $display("FAIL rstmid_path got=%0d exp=%0d", state, i);
      end
      @(posedge clk); #1;
    end
    MIO_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 5'd5 || act !== ctl_t'(0)) begin
      errors++;
      $display("FAIL rstmid_memwr state=%0d ctl=%h exp state=5 ctl=0", state, act);
    end
    @(posedge clk); #1;
    MIO_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_state got=%0d exp=0", state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("instr sw aborted by reset in MEM_WR");
  endtask

  task automatic test_illegal();
    run_instr(mk(6'b111111, 6'b101010, K_NOP, 3'b000, 0, 0), 0, 0, 1'b0);
    run_instr(mk(6'b101011, 6'b000000, K_SW, 3'b000, 0, 0), 2, 3, 1'b0);
  endtask

  task automatic test_random();
    instr_t ins;
    int     iw;
    int     mw;
    for (int i = 0; i < 250; i++) begin
      ins = tbl[$urandom_range(0, tbl.size() - 1)];
      if (ins.op != 6'b000000) ins.fun = 6'($urandom);
      iw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(ins, iw, mw, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jal();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
